itlb_refill_ctrl: RTL

ITLB miss-handling and refill controller. Accepts a single outstanding ITLB miss, issues a page-table-walk request, waits for the PTE response, then drives the PLRU replacement block (`plru_32`) to pick a victim slot and writes the translation into that slot. It owns the per-entry valid vector fed to the PLRU's `entry_valid_i`, and handles `sfence.vma` flushes.

---
 rtl/itlb_refill_ctrl_if.sv | 47 ++++
 rtl/itlb_refill_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/itlb_refill_ctrl_if.sv
// Miss, page-table-walk, PLRU, array-write and flush signals of the ITLB refill controller.
// The slave modport is the controller; the master modport is the surrounding fetch/PTW/PLRU logic.
interface itlb_refill_ctrl_if #(
  parameter int TLB_ENTRY_SIZE = 32,
  parameter int VPN_W          = 27,
  parameter int PTE_W          = 64
);
  logic                      miss_vld_i;
  logic [VPN_W-1:0]          miss_vpn_i;
  logic                      miss_rdy_o;
  logic                      ptw_req_vld_o;
  logic [VPN_W-1:0]          ptw_req_vpn_o;
  logic                      ptw_req_rdy_i;
  logic                      ptw_resp_vld_i;
  logic [PTE_W-1:0]          ptw_resp_pte_i;
  logic [1:0]                ptw_resp_level_i;
  logic                      ptw_resp_fault_i;
  logic                      plru_refill_rq_o;
  logic                      plru_refill_vld_o;
  logic [TLB_ENTRY_SIZE-1:0] plru_refill_onehot_i;
  logic [TLB_ENTRY_SIZE-1:0] entry_valid_o;
  logic                      wr_en_o;
  logic [TLB_ENTRY_SIZE-1:0] wr_onehot_o;
  logic [VPN_W-1:0]          wr_vpn_o;
  logic [PTE_W-1:0]          wr_pte_o;
  logic [1:0]                wr_level_o;
  logic                      flush_i;
  logic                      fault_vld_o;
  logic [VPN_W-1:0]          fault_vpn_o;
  logic                      busy_o;

  modport slave (
    input  miss_vld_i, miss_vpn_i, ptw_req_rdy_i, ptw_resp_vld_i, ptw_resp_pte_i,
           ptw_resp_level_i, ptw_resp_fault_i, plru_refill_onehot_i, flush_i,
    output miss_rdy_o, ptw_req_vld_o, ptw_req_vpn_o, plru_refill_rq_o, plru_refill_vld_o,
           entry_valid_o, wr_en_o, wr_onehot_o, wr_vpn_o, wr_pte_o, wr_level_o,
           fault_vld_o, fault_vpn_o, busy_o
  );

  modport master (
    output miss_vld_i, miss_vpn_i, ptw_req_rdy_i, ptw_resp_vld_i, ptw_resp_pte_i,
           ptw_resp_level_i, ptw_resp_fault_i, plru_refill_onehot_i, flush_i,
    input  miss_rdy_o, ptw_req_vld_o, ptw_req_vpn_o, plru_refill_rq_o, plru_refill_vld_o,
           entry_valid_o, wr_en_o, wr_onehot_o, wr_vpn_o, wr_pte_o, wr_level_o,
           fault_vld_o, fault_vpn_o, busy_o
  );
endinterface

// File: rtl/itlb_refill_ctrl.sv
// ITLB refill controller: one miss in flight, PTW request, PLRU victim pick, array write, flush.
// Write lands 2 cycles after the PTW response (fault report 1 cycle); misses accepted only in IDLE.
module itlb_refill_ctrl #(
  parameter int TLB_ENTRY_SIZE = 32,
  parameter int VPN_W          = 27,
  parameter int PTE_W          = 64
) (
  input logic               clk_i,
  input logic               rstn_i,
  itlb_refill_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PTW_REQ, PTW_WAIT, SLOT, WRITE, FAULT} state_e;

  state_e                    state_q;
  logic                      drop_q;
  logic [VPN_W-1:0]          vpn_q;
  logic [PTE_W-1:0]          pte_q;
  logic [1:0]                level_q;
  logic [TLB_ENTRY_SIZE-1:0] entry_valid_q, entry_valid_d;
  logic                      miss_rdy_q, busy_q, ptw_req_vld_q;
  logic                      plru_refill_rq_q, plru_refill_vld_q, wr_en_q, fault_vld_q;

  // Flush wins over a same-cycle WRITE set.
  always_comb begin
    entry_valid_d = entry_valid_q;
    if (state_q == WRITE) entry_valid_d = entry_valid_q | bus.plru_refill_onehot_i;
    if (bus.flush_i) entry_valid_d = '0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q           <= IDLE;
      drop_q            <= 1'b0;
      vpn_q             <= '0;
      pte_q             <= '0;
      level_q           <= '0;
      entry_valid_q     <= '0;
      miss_rdy_q        <= 1'b1;
      busy_q            <= 1'b0;
      ptw_req_vld_q     <= 1'b0;
      plru_refill_rq_q  <= 1'b0;
      plru_refill_vld_q <= 1'b0;
      wr_en_q           <= 1'b0;
      fault_vld_q       <= 1'b0;
    end else begin
      entry_valid_q     <= entry_valid_d;
      plru_refill_rq_q  <= 1'b0;
      plru_refill_vld_q <= 1'b0;
      wr_en_q           <= 1'b0;
      fault_vld_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.miss_vld_i) begin
            vpn_q         <= bus.miss_vpn_i;
            state_q       <= PTW_REQ;
            ptw_req_vld_q <= 1'b1;
            miss_rdy_q    <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        PTW_REQ: begin
          if (bus.flush_i) drop_q <= 1'b1;
          if (bus.ptw_req_rdy_i) begin
            ptw_req_vld_q <= 1'b0;
            state_q       <= PTW_WAIT;
          end
        end
        PTW_WAIT: begin
          if (bus.flush_i) drop_q <= 1'b1;
          if (bus.ptw_resp_vld_i) begin
            // A flushed walk is consumed silently, whatever its outcome.
            if (drop_q || bus.flush_i) begin
              state_q    <= IDLE;
              drop_q     <= 1'b0;
              miss_rdy_q <= 1'b1;
              busy_q     <= 1'b0;
            end else if (bus.ptw_resp_fault_i) begin
              state_q     <= FAULT;
              fault_vld_q <= 1'b1;
            end else begin
              pte_q            <= bus.ptw_resp_pte_i;
              level_q          <= bus.ptw_resp_level_i;
              state_q          <= SLOT;
              plru_refill_rq_q <= 1'b1;
            end
          end
        end
        SLOT: begin
          if (bus.flush_i) begin
            state_q    <= IDLE;
            drop_q     <= 1'b0;
            miss_rdy_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            state_q           <= WRITE;
            wr_en_q           <= 1'b1;
            plru_refill_vld_q <= 1'b1;
          end
        end
        WRITE, FAULT: begin
          state_q    <= IDLE;
          drop_q     <= 1'b0;
          miss_rdy_q <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          drop_q     <= 1'b0;
          miss_rdy_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.miss_rdy_o        = miss_rdy_q;
  assign bus.busy_o            = busy_q;
  assign bus.ptw_req_vld_o     = ptw_req_vld_q;
  assign bus.ptw_req_vpn_o     = vpn_q;
  assign bus.plru_refill_rq_o  = plru_refill_rq_q;
  assign bus.plru_refill_vld_o = plru_refill_vld_q;
  assign bus.entry_valid_o     = entry_valid_q;
  assign bus.wr_en_o           = wr_en_q;
  // The PLRU presents its registered victim during WRITE; pass it straight to the array.
  assign bus.wr_onehot_o       = wr_en_q ? bus.plru_refill_onehot_i : '0;
  assign bus.wr_vpn_o          = vpn_q;
  assign bus.wr_pte_o          = pte_q;
  assign bus.wr_level_o        = level_q;
  assign bus.fault_vld_o       = fault_vld_q;
  assign bus.fault_vpn_o       = vpn_q;
endmodule
